// File: rtl/switch_pkg.sv
// Shared definitions for the switch debounce bank.
//   state_t                  : per-channel debounce FSM state
//   cnt_width()              : width of a counter able to hold 0..n
//   DEFAULT_DEBOUNCE_50MHZ   : 10 ms debounce window at 50 MHz
package switch_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_STABLE = 2'd1,
        ST_CHECK  = 2'd2
    } state_t;

    localparam int DEFAULT_DEBOUNCE_50MHZ = 500000;

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/switch_debounce_channel.sv
// One switch channel: input synchroniser, debounce FSM with counter, and
// registered level / rise / fall / toggle outputs.
// Ports:
//   clock, reset   : clock and async active-low reset (already release-synchronised)
//   sw_raw         : unsynchronised pin
//   sw_level       : debounced level
//   pulse_rise/fall/toggle : one-cycle pulses on an accepted change
//   accept         : combinational "change accepted on the next edge", used by
//                    the top to register any_toggle in step with pulse_toggle
module switch_debounce_channel
    import switch_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_50MHZ
) (
    input  logic clock,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_level,
    output logic pulse_rise,
    output logic pulse_fall,
    output logic pulse_toggle,
    output logic accept
);

    localparam int CNT_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int INIT_W = cnt_width(SYNC_STAGES);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [INIT_W-1:0] INIT_MAX = INIT_W'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sw_sync;
    logic [CNT_W-1:0]       cnt;
    logic [INIT_W-1:0]      init_cnt;
    state_t                 state;

    assign sw_sync = sync_q[SYNC_STAGES-1];
    assign accept  = (state == ST_CHECK) && (sw_sync != sw_level) && (cnt == CNT_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q       <= '0;
            cnt          <= '0;
            init_cnt     <= '0;
            state        <= ST_INIT;
            sw_level     <= 1'b0;
            pulse_rise   <= 1'b0;
            pulse_fall   <= 1'b0;
            pulse_toggle <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], sw_raw};
            pulse_rise   <= 1'b0;
            pulse_fall   <= 1'b0;
            pulse_toggle <= 1'b0;
            case (state)
                // Wait for the synchroniser to fill, then adopt its value
                // silently so a switch already up at power-on makes no pulse.
                ST_INIT: begin
                    if (init_cnt == INIT_MAX) begin
                        sw_level <= sw_sync;
                        state    <= ST_STABLE;
                    end else begin
                        init_cnt <= init_cnt + INIT_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (sw_sync != sw_level) begin
                        cnt   <= CNT_W'(1);
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (sw_sync == sw_level) begin
                        cnt   <= '0;
                        state <= ST_STABLE;
                    end else if (cnt == CNT_MAX) begin
                        sw_level     <= sw_sync;
                        pulse_rise   <= sw_sync;
                        pulse_fall   <= ~sw_sync;
                        pulse_toggle <= 1'b1;
                        cnt          <= '0;
                        state        <= ST_STABLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: rtl/switch_debounce_bank.sv
// Multi-channel switch/key conditioner for board pins.
// Ports:
//   clock        : system clock
//   reset        : async active-low reset; release is synchronised internally
//   sw_raw       : unsynchronised pins, one per channel
//   sw_level     : debounced levels
//   pulse_rise   : one-cycle pulse per accepted 0->1 change
//   pulse_fall   : one-cycle pulse per accepted 1->0 change
//   pulse_toggle : rise | fall per channel
//   any_toggle   : OR of pulse_toggle, registered in the same cycle
module switch_debounce_bank
    import switch_pkg::*;
#(
    parameter int CHANNELS        = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_50MHZ
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] sw_raw,
    output logic [CHANNELS-1:0] sw_level,
    output logic [CHANNELS-1:0] pulse_rise,
    output logic [CHANNELS-1:0] pulse_fall,
    output logic [CHANNELS-1:0] pulse_toggle,
    output logic                any_toggle
);

    // Reset asserts immediately, releases two edges later.
    logic [1:0]          rst_q;
    logic                rst_sync;
    logic [CHANNELS-1:0] accept;

    assign rst_sync = rst_q[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rst_q <= '0;
        else        rst_q <= {rst_q[0], 1'b1};
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        switch_debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clock        (clock),
            .reset        (rst_sync),
            .sw_raw       (sw_raw[i]),
            .sw_level     (sw_level[i]),
            .pulse_rise   (pulse_rise[i]),
            .pulse_fall   (pulse_fall[i]),
            .pulse_toggle (pulse_toggle[i]),
            .accept       (accept[i])
        );
    end

    // Registered from the per-channel accept terms so it lines up with pulse_toggle.
    always_ff @(posedge clock or negedge rst_sync) begin
        if (!rst_sync) any_toggle <= 1'b0;
        else           any_toggle <= |accept;
    end

endmodule

// File: tb/tb_switch_debounce_bank.sv
module tb_switch_debounce_bank;

    localparam int LAT8 = 11;  // sync 2 + debounce 8 + 1
    localparam int LAT1 = 4;   // sync 2 + debounce 1 + 1

    typedef struct {
        logic [3:0] raw;
        int         hold;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    typedef struct {
        int         dut;
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] raw0  = 4'b0101;
    logic [3:0] raw1  = 4'b0000;

    logic [1:0][3:0] lvl, rise, fall, tog;
    logic [1:0]      any;

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    bit         chk_en = 1'b0;
    logic [1:0][3:0] exp_lvl;
    ev_t        evq[$];
    vec_t       tbl[9];

    always #5 clock = ~clock;

    switch_debounce_bank #(.CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8)) dut0 (
        .clock(clock), .reset(reset), .sw_raw(raw0), .sw_level(lvl[0]),
        .pulse_rise(rise[0]), .pulse_fall(fall[0]), .pulse_toggle(tog[0]), .any_toggle(any[0])
    );

    switch_debounce_bank #(.CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut1 (
        .clock(clock), .reset(reset), .sw_raw(raw1), .sw_level(lvl[1]),
        .pulse_rise(rise[1]), .pulse_fall(fall[1]), .pulse_toggle(tog[1]), .any_toggle(any[1])
    );

    task automatic chk(input string name, input int d, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d cyc %0d: got %b expected %b", name, d, cyc, act, exp);
        end
    endtask

    // Pop every event due this cycle and compare all outputs of both DUTs.
    task automatic scoreboard();
        logic [3:0] er, ef;
        for (int d = 0; d < 2; d++) begin
            er = '0;
            ef = '0;
            for (int i = evq.size() - 1; i >= 0; i--) begin
                if (evq[i].dut == d && evq[i].cyc == cyc) begin
                    er |= evq[i].rise;
                    ef |= evq[i].fall;
                    evq.delete(i);
                end
            end
            exp_lvl[d] = (exp_lvl[d] | er) & ~ef;
            chk("level",  d, lvl[d],  exp_lvl[d]);
            chk("rise",   d, rise[d], er);
            chk("fall",   d, fall[d], ef);
            chk("toggle", d, tog[d],  er | ef);
            chk("any",    d, {3'b000, any[d]}, {3'b000, |(er | ef)});
        end
    endtask

    // Compare at the falling edge, then advance to just after the next rising edge.
    task automatic step();
        @(negedge clock);
        if (chk_en) scoreboard();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic chk_quiet(input string name);
        for (int d = 0; d < 2; d++)
            chk(name, d, rise[d] | fall[d] | tog[d] | {3'b000, any[d]}, 4'b0000);
    endtask

    task automatic push(input int d, input int lat, input logic [3:0] r, input logic [3:0] f);
        ev_t e;
        e.dut  = d;
        e.cyc  = cyc + lat;
        e.rise = r;
        e.fall = f;
        evq.push_back(e);
    endtask

    initial begin
        tbl[0] = '{4'b0100, 20, 4'b0000, 4'b0001};  // ch0 down
        tbl[1] = '{4'b0101, 20, 4'b0001, 4'b0000};  // ch0 clean rise
        tbl[2] = '{4'b0111,  3, 4'b0000, 4'b0000};  // ch1 bounce
        tbl[3] = '{4'b0101,  3, 4'b0000, 4'b0000};
        tbl[4] = '{4'b0111,  3, 4'b0000, 4'b0000};
        tbl[5] = '{4'b0101,  3, 4'b0000, 4'b0000};
        tbl[6] = '{4'b0111, 20, 4'b0010, 4'b0000};  // ch1 settles high
        tbl[7] = '{4'b1011, 20, 4'b1000, 4'b0100};  // ch3 up, ch2 down
        tbl[8] = '{4'b0111, 20, 4'b0100, 4'b1000};  // ch2 up, ch3 down

        // Reset state with raw switches already up.
        @(posedge clock);
        #1;
        cyc = 1;
        chk_quiet("reset_pulses");
        for (int d = 0; d < 2; d++) chk("reset_level", d, lvl[d], 4'b0000);
        step();
        step();
        reset = 1'b1;

        // INIT loads the raw level silently.
        step();
        for (int d = 0; d < 2; d++) chk("init_early", d, lvl[d], 4'b0000);
        for (int k = 0; k < 10; k++) begin
            step();
            chk_quiet("init_pulses");
        end
        chk("init_level", 0, lvl[0], 4'b0101);
        chk("init_level", 1, lvl[1], 4'b0000);

        exp_lvl[0] = 4'b0101;
        exp_lvl[1] = 4'b0000;
        chk_en = 1'b1;
        foreach (tbl[v]) begin
            raw0 = tbl[v].raw;
            if ((tbl[v].rise | tbl[v].fall) != 4'b0000) push(0, LAT8, tbl[v].rise, tbl[v].fall);
            repeat (tbl[v].hold) step();
        end

        // Reset while ch0 is mid-CHECK (counter at 5).
        raw0 = 4'b0110;
        repeat (7) step();
        chk_en = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk_quiet("midreset_pulses");
        for (int d = 0; d < 2; d++) chk("midreset_level", d, lvl[d], 4'b0000);
        @(posedge clock);
        #1;
        cyc++;
        step();
        step();
        reset = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            chk_quiet("post_reset_pulses");
        end
        chk("post_reset_level", 0, lvl[0], 4'b0110);
        chk("post_reset_level", 1, lvl[1], 4'b0000);

        // DEBOUNCE_CYCLES = 1: alternate rise/fall every 10 cycles.
        exp_lvl[0] = 4'b0110;
        exp_lvl[1] = 4'b0000;
        chk_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            raw1[0] = ~raw1[0];
            push(1, LAT1, {3'b000, raw1[0]}, {3'b000, ~raw1[0]});
            repeat (10) step();
        end
        repeat (15) step();

        n_cmp++;
        if (evq.size() != 0) begin
            n_err++;
            $display("FAIL pending_events: got %0d left expected 0", evq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
